// File: rtl/mem_arb_pkg.sv
// Shared constants and encodings for the memory-port arbiter.
// State codes double as grant-select codes so a decision maps directly to the next state.
package mem_arb_pkg;

    localparam int DEF_ADDR_W       = 28;
    localparam int DEF_DATA_W       = 128;
    localparam int DEF_STARVE_LIMIT = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_I    = 2'd1,
        SEL_D    = 2'd2
    } gnt_sel_e;

    // D wins unless I is waiting and D has used up its consecutive-grant allowance.
    function automatic gnt_sel_e pick_winner(input logic i_req,
                                             input logic d_req,
                                             input logic d_allowed);
        gnt_sel_e sel;
        sel = SEL_NONE;
        if (d_req && (!i_req || d_allowed)) begin
            sel = SEL_D;
        end else if (i_req) begin
            sel = SEL_I;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of D grants taken while an I request waits.
// d_allowed_o drops once the count reaches LIMIT, handing the next grant to I.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic d_allowed_o
);

    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign d_allowed_o = (cnt_q < LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between I-cache and D-cache block transfers.
// Build option MEM_ARB_PERF_CNT_EN adds grant and wait-cycle performance counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state_o
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_wait_cycles
`endif
);

    // Handshake: a requester holds read/write (its valid) level-high until its
    // *_mem_ready pulses; the pulse is mem_ready gated by the owning grant state,
    // and the requester may change or drop its request from the following cycle.

    logic [1:0]        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic     i_req, d_req;
    logic     d_allowed;
    logic     starve_inc, starve_clr;
    logic     gnt_i, gnt_d;
    gnt_sel_e sel;

    assign i_req = i_mem_read | i_mem_write;
    assign d_req = d_mem_read | d_mem_write;
    assign sel   = pick_winner(i_req, d_req, d_allowed);
    assign gnt_i = (state_q == ST_IDLE) && (sel == SEL_I);
    assign gnt_d = (state_q == ST_IDLE) && (sel == SEL_D);

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        starve_inc  = 1'b0;
        starve_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                starve_clr = !i_req;
                if (gnt_d) begin
                    state_d     = ST_GNT_D;
                    mem_read_d  = d_mem_read;
                    mem_write_d = d_mem_write;
                    mem_addr_d  = d_mem_addr;
                    mem_wdata_d = d_mem_wdata;
                    starve_inc  = i_req;
                end else if (gnt_i) begin
                    state_d     = ST_GNT_I;
                    mem_read_d  = i_mem_read;
                    mem_write_d = i_mem_write;
                    mem_addr_d  = i_mem_addr;
                    mem_wdata_d = i_mem_wdata;
                    starve_clr  = 1'b1;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (mem_ready) begin
                    state_d     = ST_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    mem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (starve_inc),
        .clr_i      (starve_clr),
        .d_allowed_o(d_allowed)
    );

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign i_mem_ready = mem_ready && (state_q == ST_GNT_I);
    assign d_mem_ready = mem_ready && (state_q == ST_GNT_D);
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;
    assign dbg_state_o = state_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_i_q, perf_d_q, perf_wait_q;
    logic        waiting;

    // A request waits whenever its owner is not the requester currently granted.
    assign waiting = (i_req && (state_q != ST_GNT_I)) || (d_req && (state_q != ST_GNT_D));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_i_q    <= '0;
            perf_d_q    <= '0;
            perf_wait_q <= '0;
        end else begin
            if (gnt_i) perf_i_q <= perf_i_q + 32'd1;
            if (gnt_d) perf_d_q <= perf_d_q + 32'd1;
            if (waiting) perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_i_grants    = perf_i_q;
    assign perf_d_grants    = perf_d_q;
    assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency memory model and grant/ready scoreboards.
// Perf counter checks are compiled in when MEM_ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MEM_LAT = 4;
  localparam int BUDGET = 200;

  logic clk;
  logic rst_n;
  logic i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
  logic [DW-1:0] i_mem_wdata, d_mem_wdata, i_mem_rdata, d_mem_rdata;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic i_mem_ready, d_mem_ready, mem_read, mem_write, mem_ready;
  logic [1:0] dbg_state_o;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_wait_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic stray;

  // grant scoreboard: {write, addr}; ready scoreboard: {i_ready, d_ready, addr}
  logic [AW:0] exp_q[$];
  logic [AW+1:0] rdy_q[$];

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state_o(dbg_state_o)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memory model: fixed latency, one-cycle ready pulse, optional stray pulse
  initial begin : mem_model
    int lat_cnt;
    logic busy;
    busy = 1'b0;
    lat_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy = 1'b0;
        mem_ready = 1'b0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        busy = 1'b0;
      end else if (busy) begin
        if (lat_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = model_rdata(mem_addr);
        end else begin
          lat_cnt--;
        end
      end else if (mem_read || mem_write) begin
        busy = 1'b1;
        lat_cnt = MEM_LAT;
      end else if (stray) begin
        mem_ready = 1'b1;
        mem_rdata = '1;
        stray = 1'b0;
      end
    end
  end

  // grant monitor: each rising memory strobe is one grant
  initial begin : grant_mon
    logic prev;
    logic [AW:0] g;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((mem_read || mem_write) && !prev) begin
        chk("grant_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          g = exp_q.pop_front();
          chk("grant_wr_addr", {mem_write, mem_addr}, g);
        end
      end
      prev = mem_read || mem_write;
    end
  end

  // ready monitor: completion pulses checked against the ready scoreboard
  initial begin : ready_mon
    logic [AW+1:0] e;
    forever begin
      @(negedge clk);
      if (i_mem_ready || d_mem_ready) begin
        chk("ready_expected", rdy_q.size() != 0, 1'b1);
        if (rdy_q.size() != 0) begin
          e = rdy_q.pop_front();
          chk("ready_who", {i_mem_ready, d_mem_ready}, e[AW+1:AW]);
          if (e[AW+1]) chk("i_rdata", i_mem_rdata, model_rdata(e[AW-1:0]));
          else chk("d_rdata", d_mem_rdata, model_rdata(e[AW-1:0]));
        end
      end
    end
  end

  // driver: run until n_i I readies and n_d D readies, dropping each request at its last ready
  task automatic serve(input int n_i, input int n_d, input string tag);
    int ci, cd, cyc;
    ci = 0;
    cd = 0;
    cyc = 0;
    while ((ci < n_i || cd < n_d) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (i_mem_ready) begin
        ci++;
        if (ci >= n_i) begin i_mem_read = 1'b0; i_mem_write = 1'b0; end
      end
      if (d_mem_ready) begin
        cd++;
        if (cd >= n_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
      end
    end
    chk({tag, "_timeout"}, cyc < BUDGET, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    stray = 1'b0;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_addr = '0; i_mem_wdata = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_state", dbg_state_o, ST_IDLE);
    chk("rst_readies", {i_mem_ready, d_mem_ready}, 2'b00);
    chk("rst_rdata_pass", i_mem_rdata, mem_rdata);
    rst_n = 1'b1;
    @(negedge clk);

    // D read alone: strobe one cycle after request
    exp_q.push_back({1'b0, 28'h10});
    rdy_q.push_back({2'b01, 28'h10});
    d_mem_read = 1'b1; d_mem_addr = 28'h10;
    @(negedge clk);
    chk("s1_mem_read", mem_read, 1'b1);
    chk("s1_mem_addr", mem_addr, 28'h10);
    chk("s1_state", dbg_state_o, ST_GNT_D);
    serve(0, 1, "s1");
    @(negedge clk);
    chk("s1_idle", dbg_state_o, ST_IDLE);
    chk("s1_strobe_clr", mem_read, 1'b0);

    // simultaneous I and D: D first, I after one idle cycle
    exp_q.push_back({1'b0, 28'h100});
    exp_q.push_back({1'b0, 28'h200});
    rdy_q.push_back({2'b01, 28'h100});
    rdy_q.push_back({2'b10, 28'h200});
    d_mem_read = 1'b1; d_mem_addr = 28'h100;
    i_mem_read = 1'b1; i_mem_addr = 28'h200;
    serve(0, 1, "s2a");
    @(negedge clk);
    chk("s2_gap_strobe", mem_read, 1'b0);
    chk("s2_gap_state", dbg_state_o, ST_IDLE);
    @(negedge clk);
    chk("s2_i_strobe", mem_read, 1'b1);
    chk("s2_i_addr", mem_addr, 28'h200);
    chk("s2_i_state", dbg_state_o, ST_GNT_I);
    serve(1, 0, "s2b");
    @(negedge clk);

    // continuous D with I waiting: D,D,D,D,I,D
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, 28'h300});
      rdy_q.push_back({2'b01, 28'h300});
    end
    exp_q.push_back({1'b0, 28'h400});
    rdy_q.push_back({2'b10, 28'h400});
    exp_q.push_back({1'b0, 28'h300});
    rdy_q.push_back({2'b01, 28'h300});
    d_mem_read = 1'b1; d_mem_addr = 28'h300;
    i_mem_read = 1'b1; i_mem_addr = 28'h400;
    serve(1, 5, "s3");
    @(negedge clk);

    // D write-back then D read after one idle cycle
    exp_q.push_back({1'b1, 28'h20});
    rdy_q.push_back({2'b01, 28'h20});
    exp_q.push_back({1'b0, 28'h40});
    rdy_q.push_back({2'b01, 28'h40});
    d_mem_write = 1'b1; d_mem_addr = 28'h20; d_mem_wdata = {16{8'hA5}};
    @(negedge clk);
    chk("s4_mem_write", mem_write, 1'b1);
    chk("s4_mem_read", mem_read, 1'b0);
    chk("s4_mem_addr", mem_addr, 28'h20);
    chk("s4_mem_wdata", mem_wdata, {16{8'hA5}});
    serve(0, 1, "s4a");
    d_mem_read = 1'b1; d_mem_addr = 28'h40;
    @(negedge clk);
    chk("s4_gap_read", mem_read, 1'b0);
    chk("s4_gap_write", mem_write, 1'b0);
    @(negedge clk);
    chk("s4_rd_strobe", mem_read, 1'b1);
    chk("s4_rd_addr", mem_addr, 28'h40);
    serve(0, 1, "s4b");
    @(negedge clk);

    // reset during an I grant abandons the transfer
    exp_q.push_back({1'b0, 28'h500});
    i_mem_read = 1'b1; i_mem_addr = 28'h500;
    @(negedge clk);
    chk("s5_gnt_state", dbg_state_o, ST_GNT_I);
    chk("s5_gnt_strobe", mem_read, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    i_mem_read = 1'b0;
    @(negedge clk);
    chk("s5_rst_strobe", mem_read, 1'b0);
    chk("s5_rst_state", dbg_state_o, ST_IDLE);
    chk("s5_rst_readies", {i_mem_ready, d_mem_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({1'b0, 28'h600});
    rdy_q.push_back({2'b10, 28'h600});
    i_mem_read = 1'b1; i_mem_addr = 28'h600;
    @(negedge clk);
    chk("s5_fresh_strobe", mem_read, 1'b1);
    serve(1, 0, "s5");
    @(negedge clk);

    // stray mem_ready in IDLE produces no completion pulse
    stray = 1'b1;
    @(negedge clk);
    chk("s6_stray_seen", mem_ready, 1'b1);
    chk("s6_readies", {i_mem_ready, d_mem_ready}, 2'b00);
    chk("s6_state", dbg_state_o, ST_IDLE);
    @(negedge clk);
    chk("s6_strobe", mem_read, 1'b0);

`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_i_grants", perf_i_grants, 32'd1);
    chk("perf_d_grants", perf_d_grants, 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("grant_q_empty", exp_q.size(), 0);
    chk("rdy_q_empty", rdy_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
